jbus_xfer: RTL and testbench
============================

Name: jbus_xfer

Overview:
- Parametrised register-transfer sequencer for the shared CPU bus: NREGS general registers plus an external data source, all on one WIDTH-bit wired-OR bus.
- Takes a single command (MOV, SWAP, CLR) with a start pulse and generates the enable/set timing itself, as a multi-cycle handshake with busy/done/err.
- Internal TMP register for SWAP; exposes the one-hot enable/set vectors and the bus for LED display on the demo board.

Parameters:
- WIDTH, 8, bus and register width in bits.
- NREGS, 4, number of general registers, addressed 1..NREGS. Selector code 0 is the external data input DIN.
- SELW, 3, selector width. Must satisfy 2^SELW >= NREGS+1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  command request; sampled only in IDLE.
- OP  in  2  command: 0 MOV, 1 SWAP, 2 CLR, 3 reserved.
- SRC  in  SELW  source selector: 0 = DIN, 1..NREGS = register.
- DST  in  SELW  destination selector: 1..NREGS.
- DIN  in  WIDTH  external data, driven onto the bus when source 0 is enabled.
- PEEK_SEL  in  SELW  combinational read-port selector.
- PEEK_DATA  out  WIDTH  contents of register PEEK_SEL. Value is 0 for PEEK_SEL=0 or PEEK_SEL>NREGS.
- BUS  out  WIDTH  current bus value: OR of all enabled sources, 0 when nothing is enabled.
- ENA_VEC  out  NREGS+2  one-hot enables. Bit 0 = DIN, bits 1..NREGS = registers, bit NREGS+1 = TMP.
- SET_VEC  out  NREGS+2  one-hot sets, same bit mapping as ENA_VEC.
- BUSY  out  1  high while a command is in progress.
- DONE  out  1  one-cycle pulse when a command completes.
- ERR  out  1  one-cycle pulse, coincident with DONE, when a command was rejected.

Behaviour:
- Reset: state IDLE. All registers and TMP = 0. BUSY=0, DONE=0, ERR=0. ENA_VEC=0, SET_VEC=0, so BUS=0.

Command capture:
- On a rising edge in IDLE with START=1, OP/SRC/DST are latched internally.
- START while BUSY=1 is ignored; no queueing.
- Inputs may change after the capture edge without affecting the command.

Transfer primitive XFER(s,d), 2 cycles:
- DRIVE: ENA_VEC[s]=1, SET_VEC=0.
- LATCH: ENA_VEC[s]=1, SET_VEC[d]=1.
- Register d loads BUS on the edge that ends LATCH.
- The source for CLR is "none": BUS=0.

State sequences:
- MOV: XFER(SRC,DST), 2 busy cycles.
- CLR: XFER(none,DST), 2 busy cycles. SRC is ignored.
- SWAP: XFER(SRC,TMP), XFER(DST,SRC), XFER(TMP,DST), 6 busy cycles.
- States: IDLE, DRIVE, LATCH, DONE. A 2-bit step counter selects the SWAP phase.

Handshake timing:
- BUSY=1 from the cycle after the capture edge through the final LATCH.
- DONE state lasts 1 cycle: DONE=1, BUSY=0, and a new START is accepted in this cycle.
- After DONE the block returns to IDLE, or goes straight to DRIVE if START was accepted.
- START-to-DONE latency: 3 cycles for MOV/CLR, 7 cycles for SWAP.

Error checks, evaluated at capture:
- Errors: DST=0 or DST>NREGS; SRC>NREGS (MOV/SWAP only); SWAP with SRC=0; OP=3.
- On error: go directly to DONE with ERR=1. No enables are asserted and no register changes. Latency is 1 cycle.

Legal edge cases:
- MOV with SRC=DST: register reloads its own value, so it is unchanged.
- SWAP with SRC=DST: register unchanged, but TMP ends holding that value.
- TMP is not addressable through SRC/DST and is not cleared after SWAP.

Other rules:
- ENA_VEC and SET_VEC are registered, with at most one bit set in each.
- The bus is never driven by two sources at once.
- Reset asserted mid-command aborts immediately: any partially written register returns to 0 along with all other state. No DONE is pulsed.

Test Plan:
- Reset, then MOV SRC=0 DST=2 with DIN=0xA5: BUSY high 2 cycles, DONE at cycle 3, PEEK_SEL=2 reads 0xA5, ERR=0, BUS=0xA5 during DRIVE/LATCH.
- Load r1=0x3C and r3=0xC3, then SWAP SRC=1 DST=3: DONE at cycle 7, r1=0xC3, r3=0x3C, TMP=0x3C. ENA_VEC/SET_VEC one-hot in every cycle.
- Error cases, each giving DONE+ERR one cycle after START with all registers unchanged: MOV DST=0; MOV SRC=5 with NREGS=4; SWAP SRC=0; OP=3.
- START held continuously for two MOVs (DIN 0x11→r1, then 0x22→r2): the second command is captured in the first command's DONE cycle. START pulses during BUSY are ignored. Final state r1=0x11, r2=0x22.
- Assert RST in the LATCH cycle of MOV 0xFF→r4: r4=0, all outputs 0, no DONE. After release, CLR of r4 completes normally with r4=0.
- Re-elaborate with WIDTH=16, NREGS=8, SELW=4: MOV DIN=0xBEEF→r8 reads back 0xBEEF; SRC=9 gives ERR.

Source files
------------

// File: rtl/jbus_xfer.sv
// jbus_xfer: register-transfer sequencer driving a shared wired-OR bus (MOV/SWAP/CLR)
module jbus_xfer #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int SELW  = 3
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic [1:0]          OP,
   input  logic [SELW-1:0]     SRC,
   input  logic [SELW-1:0]     DST,
   input  logic [WIDTH-1:0]    DIN,
   input  logic [SELW-1:0]     PEEK_SEL,
   output logic [WIDTH-1:0]    PEEK_DATA,
   output logic [WIDTH-1:0]    BUS,
   output logic [NREGS+1:0]    ENA_VEC,
   output logic [NREGS+1:0]    SET_VEC,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR
);
   localparam int NV = NREGS + 2;
   localparam logic [1:0] OP_MOV = 2'd0, OP_SWAP = 2'd1, OP_CLR = 2'd2;
   localparam logic [NV-1:0] TMP_BIT = {1'b1, {(NV-1){1'b0}}};
   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH, S_DONE} state_t;
   state_t state;
   logic [1:0] step, op_q;
   logic [SELW-1:0] src_q, dst_q;
   logic [WIDTH-1:0] regs [1:NREGS];
   logic [WIDTH-1:0] tmp;
   logic bad, last;
   function automatic logic [NV-1:0] sel_bit(input logic [SELW-1:0] s);
      return NV'(1) << s;
   endfunction
   // source driven in a given step: SWAP walks SRC->TMP, DST->SRC, TMP->DST
   function automatic logic [NV-1:0] ena_of(input logic [1:0] o, input logic [SELW-1:0] s, d, input logic [1:0] st);
      return (o == OP_CLR) ? '0 : (o == OP_MOV || st == 2'd0) ? sel_bit(s) : (st == 2'd1) ? sel_bit(d) : TMP_BIT;
   endfunction
   function automatic logic [NV-1:0] set_of(input logic [1:0] o, input logic [SELW-1:0] s, d, input logic [1:0] st);
      return (o != OP_SWAP || st == 2'd2) ? sel_bit(d) : (st == 2'd0) ? TMP_BIT : sel_bit(s);
   endfunction
   // command validity is judged on the live inputs at the capture edge
   always_comb begin
      bad = OP == 2'd3 || DST == '0 || int'(DST) > NREGS || (OP != OP_CLR && int'(SRC) > NREGS) || (OP == OP_SWAP && SRC == '0);
      last = op_q != OP_SWAP || step == 2'd2;
   end
   // sequencer: captures commands in IDLE or DONE and steps DRIVE/LATCH pairs with registered strobes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         step <= '0;
         op_q <= '0;
         src_q <= '0;
         dst_q <= '0;
         ENA_VEC <= '0;
         SET_VEC <= '0;
         BUSY <= 1'b0;
         DONE <= 1'b0;
         ERR <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (START) begin
                  op_q <= OP;
                  src_q <= SRC;
                  dst_q <= DST;
                  step <= '0;
                  state <= bad ? S_DONE : S_DRIVE;
                  BUSY <= !bad;
                  DONE <= bad;
                  ERR <= bad;
                  ENA_VEC <= bad ? '0 : ena_of(OP, SRC, DST, 2'd0);
               end else begin
                  state <= S_IDLE;
                  BUSY <= 1'b0;
               end
            end
            S_DRIVE: begin
               state <= S_LATCH;
               SET_VEC <= set_of(op_q, src_q, dst_q, step);
            end
            default: begin
               SET_VEC <= '0;
               step <= step + 2'd1;
               state <= last ? S_DONE : S_DRIVE;
               ENA_VEC <= last ? '0 : ena_of(op_q, src_q, dst_q, step + 2'd1);
               BUSY <= !last;
               DONE <= last;
            end
         endcase
      end
   end
   // register file and TMP load the bus on the edge that ends LATCH
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 1; i <= NREGS; i++) regs[i] <= '0;
         tmp <= '0;
      end else begin
         for (int i = 1; i <= NREGS; i++) if (SET_VEC[i]) regs[i] <= BUS;
         if (SET_VEC[NREGS+1]) tmp <= BUS;
      end
   end
   // wired-OR bus and combinational peek port
   always_comb begin
      BUS = {WIDTH{ENA_VEC[0]}} & DIN;
      for (int i = 1; i <= NREGS; i++) BUS = BUS | ({WIDTH{ENA_VEC[i]}} & regs[i]);
      BUS = BUS | ({WIDTH{ENA_VEC[NREGS+1]}} & tmp);
      PEEK_DATA = '0;
      for (int i = 1; i <= NREGS; i++) if (int'(PEEK_SEL) == i) PEEK_DATA = regs[i];
   end
endmodule

// File: tb/tb_jbus_xfer.sv
// tb_jbus_xfer: randomized self-checking bench for jbus_xfer against a command-level model
module tb_jbus_xfer;
   logic CLK, RST, START;
   logic [1:0] OP;
   logic [2:0] SRC, DST, PEEK_SEL;
   logic [7:0] DIN, PEEK_DATA, BUS;
   logic [5:0] ENA_VEC, SET_VEC;
   logic BUSY, DONE, ERR;
   logic START2;
   logic [1:0] OP2;
   logic [3:0] SRC2, DST2, PEEK_SEL2;
   logic [15:0] DIN2, PEEK_DATA2, BUS2;
   logic [9:0] ENA_VEC2, SET_VEC2;
   logic BUSY2, DONE2, ERR2;
   int pass_cnt = 0, total = 0;
   logic [7:0] m_r [0:5];
   logic [7:0] m_tmp;

   jbus_xfer dut (.CLK(CLK), .RST(RST), .START(START), .OP(OP), .SRC(SRC), .DST(DST), .DIN(DIN),
      .PEEK_SEL(PEEK_SEL), .PEEK_DATA(PEEK_DATA), .BUS(BUS), .ENA_VEC(ENA_VEC), .SET_VEC(SET_VEC),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR));
   jbus_xfer #(.WIDTH(16), .NREGS(8), .SELW(4)) dut2 (.CLK(CLK), .RST(RST), .START(START2), .OP(OP2),
      .SRC(SRC2), .DST(DST2), .DIN(DIN2), .PEEK_SEL(PEEK_SEL2), .PEEK_DATA(PEEK_DATA2), .BUS(BUS2),
      .ENA_VEC(ENA_VEC2), .SET_VEC(SET_VEC2), .BUSY(BUSY2), .DONE(DONE2), .ERR(ERR2));

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   function automatic bit m_bad(int op, int s, int d);
      return op == 3 || d == 0 || d > 4 || (op != 2 && s > 4) || (op == 1 && s == 0);
   endfunction

   function automatic int m_lat(int op, int s, int d);
      return m_bad(op, s, d) ? 1 : (op == 1) ? 7 : 3;
   endfunction

   task automatic m_apply(int op, int s, int d, logic [7:0] din);
      logic [7:0] t;
      if (m_bad(op, s, d)) return;
      if (op == 0) m_r[d] = (s == 0) ? din : m_r[s];
      else if (op == 2) m_r[d] = 8'h00;
      else begin
         t = m_r[s];
         m_r[s] = m_r[d];
         m_r[d] = t;
         m_tmp = t;
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i <= 5; i++) m_r[i] = 8'h00;
      m_tmp = 8'h00;
   endtask

   task automatic peek(input int sel, output logic [7:0] v);
      PEEK_SEL = 3'(sel);
      #1;
      v = PEEK_DATA;
   endtask

   // drive one command, then observe it until DONE (bounded); returns observations only
   task automatic issue(input int op, input int s, input int d, input logic [7:0] din,
                        output int lat, output logic e, output int busy_cycles, output logic oh_ok, output logic [7:0] bus0);
      OP = 2'(op); SRC = 3'(s); DST = 3'(d); DIN = din; START = 1;
      @(posedge CLK); #1;
      START = 0; OP = 2'($urandom); SRC = 3'($urandom); DST = 3'($urandom);
      lat = 1; busy_cycles = 0; oh_ok = 1; bus0 = BUS;
      while (!DONE && lat < 20) begin
         if (BUSY) busy_cycles++;
         if ($countones(ENA_VEC) > 1 || $countones(SET_VEC) > 1) oh_ok = 0;
         @(posedge CLK); #1;
         lat++;
      end
      e = ERR;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      RST = 1; START = 0; OP = 0; SRC = 0; DST = 0; DIN = 0; PEEK_SEL = 0;
      START2 = 0; OP2 = 0; SRC2 = 0; DST2 = 0; DIN2 = 0; PEEK_SEL2 = 0;
      m_reset();
      repeat (2) @(posedge CLK);
      #1;
      RST = 0;
      @(posedge CLK); #1;
      total++; if ({BUSY, DONE, ERR} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {BUSY, DONE, ERR}); else pass_cnt++;
      total++; if ({ENA_VEC, SET_VEC} !== 12'h000) $display("FAIL reset_vecs got %h exp 000", {ENA_VEC, SET_VEC}); else pass_cnt++;
      total++; if (BUS !== 8'h00) $display("FAIL reset_bus got %h exp 00", BUS); else pass_cnt++;
      for (int i = 0; i <= 5; i++) begin
         peek(i, v);
         total++; if (v !== 8'h00) $display("FAIL reset_reg%0d got %h exp 00", i, v); else pass_cnt++;
      end
   endtask

   task automatic test_mov_din();
      int lat, bc; logic e, oh; logic [7:0] b0, v;
      issue(0, 0, 2, 8'hA5, lat, e, bc, oh, b0);
      m_apply(0, 0, 2, 8'hA5);
      total++; if (lat !== 3) $display("FAIL mov_latency got %0d exp 3", lat); else pass_cnt++;
      total++; if (bc !== 2) $display("FAIL mov_busy got %0d exp 2", bc); else pass_cnt++;
      total++; if (b0 !== 8'hA5) $display("FAIL mov_bus got %h exp a5", b0); else pass_cnt++;
      total++; if (e !== 1'b0) $display("FAIL mov_err got %b exp 0", e); else pass_cnt++;
      peek(2, v);
      total++; if (v !== 8'hA5) $display("FAIL mov_r2 got %h exp a5", v); else pass_cnt++;
   endtask

   task automatic test_swap();
      int lat, bc; logic e, oh; logic [7:0] b0, v;
      issue(0, 0, 1, 8'h3C, lat, e, bc, oh, b0); m_apply(0, 0, 1, 8'h3C);
      issue(0, 0, 3, 8'hC3, lat, e, bc, oh, b0); m_apply(0, 0, 3, 8'hC3);
      issue(1, 1, 3, 8'h00, lat, e, bc, oh, b0); m_apply(1, 1, 3, 8'h00);
      total++; if (lat !== 7) $display("FAIL swap_latency got %0d exp 7", lat); else pass_cnt++;
      total++; if (bc !== 6) $display("FAIL swap_busy got %0d exp 6", bc); else pass_cnt++;
      total++; if (oh !== 1'b1) $display("FAIL swap_onehot got %b exp 1", oh); else pass_cnt++;
      total++; if (b0 !== 8'h3C) $display("FAIL swap_bus got %h exp 3c", b0); else pass_cnt++;
      peek(1, v);
      total++; if (v !== 8'hC3) $display("FAIL swap_r1 got %h exp c3", v); else pass_cnt++;
      peek(3, v);
      total++; if (v !== 8'h3C) $display("FAIL swap_r3 got %h exp 3c", v); else pass_cnt++;
      total++; if (dut.tmp !== 8'h3C) $display("FAIL swap_tmp got %h exp 3c", dut.tmp); else pass_cnt++;
   endtask

   task automatic test_errors();
      int lat, bc; logic e, oh; logic [7:0] b0, v;
      int cases [4][3] = '{'{0, 0, 0}, '{0, 5, 1}, '{1, 0, 2}, '{3, 1, 2}};
      for (int c = 0; c < 4; c++) begin
         issue(cases[c][0], cases[c][1], cases[c][2], 8'h5A, lat, e, bc, oh, b0);
         total++; if (lat !== 1 || e !== 1'b1 || bc !== 0) $display("FAIL err_case%0d got lat=%0d err=%b busy=%0d exp lat=1 err=1 busy=0", c, lat, e, bc); else pass_cnt++;
         for (int i = 1; i <= 4; i++) begin
            peek(i, v);
            total++; if (v !== m_r[i]) $display("FAIL err_case%0d_r%0d got %h exp %h", c, i, v, m_r[i]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int n, m; logic [7:0] v;
      OP = 0; SRC = 0; DST = 1; DIN = 8'h11; START = 1;
      @(posedge CLK); #1;
      n = 0;
      while (!DONE && n < 10) begin @(posedge CLK); #1; n++; end
      total++; if (n !== 2) $display("FAIL b2b_first got %0d exp 2", n); else pass_cnt++;
      DST = 2; DIN = 8'h22;
      @(posedge CLK); #1;
      total++; if (BUSY !== 1'b1) $display("FAIL b2b_capture_in_done got %b exp 1", BUSY); else pass_cnt++;
      DST = 3;
      @(posedge CLK); #1;
      START = 0;
      m = 1;
      while (!DONE && m < 10) begin @(posedge CLK); #1; m++; end
      total++; if (m !== 2) $display("FAIL b2b_second got %0d exp 2", m); else pass_cnt++;
      @(posedge CLK); #1;
      total++; if ({BUSY, DONE} !== 2'b00) $display("FAIL b2b_ignored_start got %b exp 00", {BUSY, DONE}); else pass_cnt++;
      m_r[1] = 8'h11; m_r[2] = 8'h22;
      for (int i = 1; i <= 3; i++) begin
         peek(i, v);
         total++; if (v !== m_r[i]) $display("FAIL b2b_r%0d got %h exp %h", i, v, m_r[i]); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc; logic e, oh, seen; logic [7:0] b0, v;
      OP = 0; SRC = 0; DST = 4; DIN = 8'hFF; START = 1;
      @(posedge CLK); #1; START = 0;
      @(posedge CLK); #1;
      total++; if (SET_VEC !== 6'b010000) $display("FAIL rstmid_latch got %b exp 010000", SET_VEC); else pass_cnt++;
      RST = 1; #1;
      total++; if ({BUSY, DONE, ERR, ENA_VEC, SET_VEC, BUS} !== 23'h0) $display("FAIL rstmid_outputs got %h exp 0", {BUSY, DONE, ERR, ENA_VEC, SET_VEC, BUS}); else pass_cnt++;
      m_reset();
      @(posedge CLK); #1; RST = 0;
      seen = 0;
      repeat (3) begin @(posedge CLK); #1; if (DONE) seen = 1; end
      total++; if (seen !== 1'b0) $display("FAIL rstmid_done got %b exp 0", seen); else pass_cnt++;
      peek(4, v);
      total++; if (v !== 8'h00) $display("FAIL rstmid_r4 got %h exp 00", v); else pass_cnt++;
      issue(2, 0, 4, 8'h77, lat, e, bc, oh, b0);
      total++; if (lat !== 3 || e !== 1'b0 || b0 !== 8'h00) $display("FAIL rstmid_clr got lat=%0d err=%b bus=%h exp lat=3 err=0 bus=00", lat, e, b0); else pass_cnt++;
      peek(4, v);
      total++; if (v !== 8'h00) $display("FAIL rstmid_clr_r4 got %h exp 00", v); else pass_cnt++;
   endtask

   task automatic test_random();
      int lat, bc, op, s, d, el; logic e, oh; logic [7:0] b0, v, din, eb;
      for (int k = 0; k < 40; k++) begin
         op = $urandom_range(0, 3); s = $urandom_range(0, 5); d = $urandom_range(0, 5); din = 8'($urandom);
         el = m_lat(op, s, d);
         eb = (op == 2) ? 8'h00 : (s == 0) ? din : m_r[s];
         issue(op, s, d, din, lat, e, bc, oh, b0);
         total++; if (lat !== el || e !== m_bad(op, s, d)) $display("FAIL rnd%0d_hs op=%0d s=%0d d=%0d got lat=%0d err=%b exp lat=%0d err=%b", k, op, s, d, lat, e, el, m_bad(op, s, d)); else pass_cnt++;
         total++; if (oh !== 1'b1) $display("FAIL rnd%0d_onehot got %b exp 1", k, oh); else pass_cnt++;
         if (!m_bad(op, s, d)) begin
            total++; if (b0 !== eb) $display("FAIL rnd%0d_bus got %h exp %h", k, b0, eb); else pass_cnt++;
         end
         m_apply(op, s, d, din);
         for (int i = 0; i <= 5; i++) begin
            peek(i, v);
            total++; if (v !== m_r[i]) $display("FAIL rnd%0d_r%0d got %h exp %h", k, i, v, m_r[i]); else pass_cnt++;
         end
         total++; if (dut.tmp !== m_tmp) $display("FAIL rnd%0d_tmp got %h exp %h", k, dut.tmp, m_tmp); else pass_cnt++;
      end
   endtask

   task automatic test_wide();
      int n;
      OP2 = 0; SRC2 = 0; DST2 = 8; DIN2 = 16'hBEEF; START2 = 1;
      @(posedge CLK); #1; START2 = 0;
      n = 1;
      while (!DONE2 && n < 10) begin @(posedge CLK); #1; n++; end
      total++; if (n !== 3 || ERR2 !== 1'b0) $display("FAIL wide_mov got lat=%0d err=%b exp lat=3 err=0", n, ERR2); else pass_cnt++;
      PEEK_SEL2 = 8; #1;
      total++; if (PEEK_DATA2 !== 16'hBEEF) $display("FAIL wide_r8 got %h exp beef", PEEK_DATA2); else pass_cnt++;
      @(posedge CLK); #1;
      OP2 = 0; SRC2 = 9; DST2 = 1; START2 = 1;
      @(posedge CLK); #1; START2 = 0;
      total++; if ({DONE2, ERR2} !== 2'b11) $display("FAIL wide_err got %b exp 11", {DONE2, ERR2}); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mov_din();
      test_swap();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_wide();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
